replay_buffer_mux: RTL and testbench
====================================

# replay_buffer_mux

Parametrised ping-pong spike replay buffer for the multiplexed macro-column. It captures NUM_CH parallel P-wide spike streams over one gamma window. In the next window it replays them serially, channel by channel, onto one P-wide output with a valid/ready handshake. It sits between the input spike sources and the shared (time-multiplexed) column datapath.

## Interface
- P, 64, spike lines per channel (output width)
- NUM_CH, 2, input channels multiplexed onto the output (≥1)
- DEPTH, 8, time slots captured per channel per gamma window (≥2)
- clk  in  1  clock
- grst  in  1  reset, asynchronous, active-high
- gamma_start  in  1  one-cycle pulse marking the start of a gamma window (bank swap)
- in_valid  in  1  the current time slot of all channels is present on in_data
- in_data  in  NUM_CH*P  channel c occupies bits [c*P +: P]
- out_valid  out  1  out_data holds a replayed slot
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  P  replayed spike vector
- out_ch  out  $clog2(NUM_CH) (min 1)  channel of the current slot
- out_slot  out  $clog2(DEPTH)  slot index of the current slot
- out_last  out  1  last slot of the last channel
- drop  out  1  sticky: an in_valid arrived with the write bank full
- overrun  out  1  sticky: gamma_start arrived while a replay was unfinished

## Operation
- Two banks, each NUM_CH×DEPTH×P bits plus a fill count wr_cnt (0..DEPTH). wsel selects the write bank; the other bank is the read bank.
- Capture: when in_valid=1 and wr_cnt<DEPTH, all channels are written to slot wr_cnt and wr_cnt is incremented. When wr_cnt==DEPTH, the sample is discarded and drop is set.
- On gamma_start:
  - wsel toggles.
  - The filled count of the old write bank is latched as rd_cnt.
  - The new write bank's wr_cnt becomes 0. If in_valid is high in the same cycle, that sample goes to slot 0 of the new bank and wr_cnt becomes 1.
- FSM states: IDLE, REPLAY.
  - IDLE→REPLAY on gamma_start when the bank being released has been captured at least once since reset (bank_seen flag). The first gamma_start after reset does not replay.
  - REPLAY walks ch=0..NUM_CH-1, slot=0..DEPTH-1, slot fastest. The full DEPTH slots are always replayed. Slots ≥rd_cnt output all-zero data, so the output timing is fixed per window.
  - The pointer advances only on an out_valid&&out_ready handshake.
  - REPLAY→IDLE on the handshake of the out_last beat.
  - gamma_start during REPLAY sets overrun, aborts the current replay, and restarts REPLAY from ch=0, slot=0 on the newly released bank.
- out_data, out_ch, out_slot and out_last are stable while out_valid=1 and out_ready=0.
- drop and overrun clear only on grst.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, out_slot=0, out_last=0, drop=0, overrun=0, wsel=0, wr_cnt=0, rd_cnt=0, bank_seen=0, FSM=IDLE.
- Latency: gamma_start in cycle t → first out_valid in cycle t+1 (registered outputs).
- With out_ready held at 1, the replay lasts exactly NUM_CH*DEPTH cycles. out_last is high in cycle t+NUM_CH*DEPTH.
- A capture write in cycle t is not visible to the replay until after the next gamma_start.
- A gamma_start in the same cycle as the out_last handshake is not an overrun. The next replay starts in the following cycle, with no bubble.

## Configuration
- REPLAY_BUF_STATS_EN defined adds three outputs, each 16 bits, saturating and cleared by grst:
  - drop_cnt: number of discarded samples.
  - overrun_cnt: number of aborted replays.
  - win_cnt: number of gamma windows.
- REPLAY_BUF_STATS_EN undefined: these ports and counters do not exist. Only the sticky flags remain.

## Structure
- Package replay_buf_pkg:
  - replay_state_e enum (IDLE, REPLAY).
  - Width helper functions for ch and slot indices.
  - STATS_W=16.
- Sub-module replay_bank: one bank with its storage array, wr_cnt, a write port and a combinational read port. The top instantiates two of them, plus the FSM and the output register.

## Test plan
- P=4, NUM_CH=2, DEPTH=4. Capture slots 1,2,3,4 on ch0 and 8,9,A,B on ch1, then gamma_start with out_ready=1 → output beats 1,2,3,4,8,9,A,B with out_ch 0,0,0,0,1,1,1,1. out_last on the 8th beat, which is cycle t+8.
- Partial fill: only 2 in_valid samples (ch0=5,6) in the window → replay 5,6,0,0 on ch0, then ch1 data,data,0,0. Still 8 beats.
- Backpressure: hold out_ready=0 for 3 cycles at beat 3 → out_data is held and nothing is skipped. The replay completes in 11 cycles.
- Overflow: 6 in_valid with DEPTH=4 → drop=1. Slots 0..3 hold samples 1..4. With stats enabled, drop_cnt=2.
- Overrun: a second gamma_start 3 cycles into a replay → overrun=1 and the replay restarts at ch0/slot0 with the new bank's data.
- Async reset: assert grst mid-replay between clock edges → all outputs reach their reset values immediately. The first gamma_start after deassertion produces no out_valid.

Source files
------------

// File: rtl/replay_buf_pkg.sv
// ============================================================================
// Module      : replay_buf_pkg
// Description : Shared state encoding, width helpers and constants for the
//               ping-pong spike replay buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package replay_buf_pkg;

  localparam int STATS_W = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REPLAY = 1'b1
  } replay_state_e;

  // Channel index width, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slot_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  // Fill count spans 0..DEPTH inclusive.
  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/replay_buffer_mux_bank.sv
// ============================================================================
// Module      : replay_bank
// Description : One capture bank: NUM_CH x DEPTH slots of P bits, fill count,
//               slot-wide write port and combinational per-channel read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module replay_bank
  import replay_buf_pkg::*;
#(
  parameter int P      = 64,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        grst,
  input  logic                        i_clear,
  input  logic                        i_wr_en,
  input  logic [NUM_CH*P-1:0]         i_wr_data,
  input  logic [ch_w(NUM_CH)-1:0]     i_rd_ch,
  input  logic [slot_w(DEPTH)-1:0]    i_rd_slot,
  output logic [P-1:0]                o_rd_data,
  output logic [cnt_w(DEPTH)-1:0]     o_wr_cnt
);

  localparam int SW = slot_w(DEPTH);
  localparam int NW = cnt_w(DEPTH);

  logic [NUM_CH*P-1:0] r_mem [DEPTH];
  logic [NW-1:0]       r_wr_cnt;
  logic                w_full;
  logic                w_we;
  logic [SW-1:0]       w_wr_idx;

  assign w_full   = (r_wr_cnt == NW'(DEPTH));
  // A clear restarts the fill at slot 0, so a same-cycle sample lands there.
  assign w_we     = i_wr_en && (i_clear || !w_full);
  assign w_wr_idx = i_clear ? '0 : r_wr_cnt[SW-1:0];

  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      r_wr_cnt <= '0;
    end else if (i_clear) begin
      r_wr_cnt <= i_wr_en ? NW'(1) : '0;
    end else if (w_we) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_slot][i_rd_ch*P +: P];
  assign o_wr_cnt  = r_wr_cnt;

endmodule

`default_nettype wire

// File: rtl/replay_buffer_mux.sv
// ============================================================================
// Module      : replay_buffer_mux
// Description : Ping-pong spike replay buffer; captures NUM_CH streams per gamma
//               window and replays them serially in the next window.
//               Optional statistics counters: define REPLAY_BUF_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module replay_buffer_mux
  import replay_buf_pkg::*;
#(
  parameter int P      = 64,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        grst,
  input  logic                        gamma_start,
  input  logic                        in_valid,
  input  logic [NUM_CH*P-1:0]         in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [P-1:0]                out_data,
  output logic [ch_w(NUM_CH)-1:0]     out_ch,
  output logic [slot_w(DEPTH)-1:0]    out_slot,
  output logic                        out_last,
`ifdef REPLAY_BUF_STATS_EN
  output logic [STATS_W-1:0]          drop_cnt,
  output logic [STATS_W-1:0]          overrun_cnt,
  output logic [STATS_W-1:0]          win_cnt,
`endif
  output logic                        drop,
  output logic                        overrun
);

  localparam int CW = ch_w(NUM_CH);
  localparam int SW = slot_w(DEPTH);
  localparam int NW = cnt_w(DEPTH);

  replay_state_e r_state, w_state_nxt;
  logic          r_wsel;
  logic          r_bank_seen;
  logic [NW-1:0] r_rd_cnt;

  logic [P-1:0]  w_bank_rd  [2];
  logic [NW-1:0] w_bank_cnt [2];

  logic          w_hs;
  logic          w_load;
  logic          w_valid_nxt;
  logic          w_last_nxt;
  logic [CW-1:0] w_ch_nxt;
  logic [SW-1:0] w_slot_nxt;
  logic          w_rd_sel;
  logic [NW-1:0] w_rd_lim;
  logic [P-1:0]  w_rd_data;
  logic          w_drop_ev;
  logic          w_overrun_ev;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic c_id = 1'(b);
    replay_bank #(.P(P), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) u_bank (
      .clk       (clk),
      .grst      (grst),
      .i_clear   (gamma_start && (r_wsel != c_id)),
      .i_wr_en   (in_valid && (gamma_start ? (r_wsel != c_id) : (r_wsel == c_id))),
      .i_wr_data (in_data),
      .i_rd_ch   (w_ch_nxt),
      .i_rd_slot (w_slot_nxt),
      .o_rd_data (w_bank_rd[b]),
      .o_wr_cnt  (w_bank_cnt[b])
    );
  end

  assign w_hs         = out_valid && out_ready;
  assign w_drop_ev    = in_valid && !gamma_start && (w_bank_cnt[r_wsel] == NW'(DEPTH));
  // A swap coinciding with the final handshake is a clean hand-over.
  assign w_overrun_ev = gamma_start && (r_state == REPLAY) && !(w_hs && out_last);

  // On a swap the bank being released is still addressed by r_wsel.
  assign w_rd_sel  = gamma_start ? r_wsel : ~r_wsel;
  assign w_rd_lim  = gamma_start ? w_bank_cnt[r_wsel] : r_rd_cnt;
  assign w_rd_data = (NW'(w_slot_nxt) < w_rd_lim) ? w_bank_rd[w_rd_sel] : '0;

  always_ff @(posedge clk or posedge grst) begin
    if (grst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = out_valid;
    w_ch_nxt    = out_ch;
    w_slot_nxt  = out_slot;
    w_last_nxt  = out_last;
    w_load      = 1'b0;
    if (gamma_start && r_bank_seen) begin
      w_state_nxt = REPLAY;
      w_valid_nxt = 1'b1;
      w_ch_nxt    = '0;
      w_slot_nxt  = '0;
      w_last_nxt  = 1'b0;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_valid_nxt = 1'b0;
        end
        REPLAY: begin
          if (w_hs) begin
            if (out_last) begin
              w_state_nxt = IDLE;
              w_valid_nxt = 1'b0;
              w_last_nxt  = 1'b0;
            end else begin
              w_load = 1'b1;
              if (out_slot == SW'(DEPTH - 1)) begin
                w_slot_nxt = '0;
                w_ch_nxt   = out_ch + 1'b1;
              end else begin
                w_slot_nxt = out_slot + 1'b1;
              end
              w_last_nxt = (w_ch_nxt == CW'(NUM_CH - 1)) && (w_slot_nxt == SW'(DEPTH - 1));
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      out_slot    <= '0;
      out_last    <= 1'b0;
      drop        <= 1'b0;
      overrun     <= 1'b0;
      r_wsel      <= 1'b0;
      r_rd_cnt    <= '0;
      r_bank_seen <= 1'b0;
    end else begin
      out_valid <= w_valid_nxt;
      out_ch    <= w_ch_nxt;
      out_slot  <= w_slot_nxt;
      out_last  <= w_last_nxt;
      if (w_load) out_data <= w_rd_data;
      if (w_drop_ev) drop <= 1'b1;
      if (w_overrun_ev) overrun <= 1'b1;
      if (gamma_start) begin
        r_wsel      <= ~r_wsel;
        r_rd_cnt    <= w_bank_cnt[r_wsel];
        r_bank_seen <= 1'b1;
      end
    end
  end

`ifdef REPLAY_BUF_STATS_EN
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      drop_cnt    <= '0;
      overrun_cnt <= '0;
      win_cnt     <= '0;
    end else begin
      if (w_drop_ev && (drop_cnt != '1))       drop_cnt    <= drop_cnt + 1'b1;
      if (w_overrun_ev && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + 1'b1;
      if (gamma_start && (win_cnt != '1))      win_cnt     <= win_cnt + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_replay_buffer_mux.sv
// ============================================================================
// Module      : tb_replay_buffer_mux
// Description : Self-checking bench for replay_buffer_mux (P=4, NUM_CH=2, DEPTH=4)
//               with a queue-based reference model and directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_replay_buffer_mux;

  localparam int P   = 4;
  localparam int NCH = 2;
  localparam int D   = 4;

  logic             clk = 1'b0;
  logic             grst;
  logic             gamma_start;
  logic             in_valid;
  logic [NCH*P-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [P-1:0]     out_data;
  logic [0:0]       out_ch;
  logic [1:0]       out_slot;
  logic             out_last;
  logic             drop;
  logic             overrun;
`ifdef REPLAY_BUF_STATS_EN
  logic [15:0]      drop_cnt, overrun_cnt, win_cnt;
`endif

  replay_buffer_mux #(.P(P), .NUM_CH(NCH), .DEPTH(D)) dut (
    .clk         (clk),
    .grst        (grst),
    .gamma_start (gamma_start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_slot    (out_slot),
    .out_last    (out_last),
`ifdef REPLAY_BUF_STATS_EN
    .drop_cnt    (drop_cnt),
    .overrun_cnt (overrun_cnt),
    .win_cnt     (win_cnt),
`endif
    .drop        (drop),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: banks as arrays, replay as a beat queue
  typedef struct packed {
    logic [P-1:0] data;
    logic         ch;
    logic [1:0]   slot;
    logic         last;
  } beat_t;

  beat_t            q[$];
  logic [NCH*P-1:0] m_bank [2][D];
  int               m_cnt [2];
  int               m_wsel;
  bit               m_seen, m_drop, m_overrun;
  int               m_drop_n, m_ovr_n, m_win_n;

  always @(posedge clk or posedge grst) begin
    if (grst) begin
      q.delete();
      m_cnt[0] = 0; m_cnt[1] = 0; m_wsel = 0; m_seen = 0;
      m_drop = 0; m_overrun = 0; m_drop_n = 0; m_ovr_n = 0; m_win_n = 0;
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (gamma_start) begin
        m_win_n++;
        if (q.size() > 0) begin
          m_overrun = 1;
          m_ovr_n++;
        end
        q.delete();
        if (m_seen) begin
          for (int c = 0; c < NCH; c++)
            for (int s = 0; s < D; s++) begin
              beat_t bt;
              bt.data = (s < m_cnt[m_wsel]) ? m_bank[m_wsel][s][c*P +: P] : '0;
              bt.ch   = 1'(c);
              bt.slot = 2'(s);
              bt.last = (c == NCH - 1) && (s == D - 1);
              q.push_back(bt);
            end
        end
        m_seen = 1;
        m_wsel = 1 - m_wsel;
        m_cnt[m_wsel] = 0;
        if (in_valid) begin
          m_bank[m_wsel][0] = in_data;
          m_cnt[m_wsel] = 1;
        end
      end else if (in_valid) begin
        if (m_cnt[m_wsel] < D) begin
          m_bank[m_wsel][m_cnt[m_wsel]] = in_data;
          m_cnt[m_wsel]++;
        end else begin
          m_drop = 1;
          m_drop_n++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !grst) begin
      chk("cmp_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("cmp_data", 32'(out_data), 32'(q[0].data));
        chk("cmp_ch",   32'(out_ch),   32'(q[0].ch));
        chk("cmp_slot", 32'(out_slot), 32'(q[0].slot));
        chk("cmp_last", 32'(out_last), 32'(q[0].last));
      end
      chk("cmp_drop",    32'(drop),    32'(m_drop));
      chk("cmp_overrun", 32'(overrun), 32'(m_overrun));
    end
  end

  // ---------------- stimulus
  task automatic cyc(input logic gs, input logic iv, input logic [NCH*P-1:0] d, input logic rdy);
    gamma_start = gs;
    in_valid    = iv;
    in_data     = d;
    out_ready   = rdy;
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (out_valid && n < bound) begin
      cyc(0, 0, '0, 1);
      n++;
    end
    chk(name, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [3:0] e1 [8];
    logic [3:0] e2 [8];
    int n;
    e1 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB};
    e2 = '{4'h5, 4'h6, 4'h0, 4'h0, 4'hC, 4'hD, 4'h0, 4'h0};

    grst = 1'b1; gamma_start = 0; in_valid = 0; in_data = '0; out_ready = 0;
    repeat (3) @(negedge clk);
    grst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_drop",  32'(drop),      0);
    chk("rst_ovr",   32'(overrun),   0);

    // Basic capture and replay.
    cyc(1, 0, '0, 1);
    chk("first_gs_no_replay", 32'(out_valid), 0);
    cyc(0, 1, 8'h81, 1); cyc(0, 1, 8'h92, 1); cyc(0, 1, 8'hA3, 1); cyc(0, 1, 8'hB4, 1);
    cyc(1, 0, '0, 1);
    for (int k = 0; k < 8; k++) begin
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_data",  32'(out_data), 32'(e1[k]));
      chk("t1_ch",    32'(out_ch),   32'(k / 4));
      chk("t1_last",  32'(out_last), 32'(k == 7));
      cyc(0, 0, '0, 1);
    end
    chk("t1_end", 32'(out_valid), 0);

    // Partial fill.
    cyc(0, 1, 8'hC5, 1); cyc(0, 1, 8'hD6, 1);
    cyc(1, 0, '0, 1);
    for (int k = 0; k < 8; k++) begin
      chk("t2_data", 32'(out_data), 32'(e2[k]));
      cyc(0, 0, '0, 1);
    end
    chk("t2_end", 32'(out_valid), 0);

    // Backpressure at beat 3 for three cycles.
    for (int k = 0; k < 4; k++) cyc(0, 1, 8'($urandom), 1);
    cyc(1, 0, '0, 1);
    n = 0;
    while (out_valid && n < 30) begin
      n++;
      cyc(0, 0, '0, (n < 4 || n > 6));
    end
    chk("bp_len", 32'(n), 32'd11);
    chk("pre_drop", 32'(drop), 0);

    // Overflow, then overrun mid-replay.
    for (int k = 1; k <= 6; k++) cyc(0, 1, 8'(k * 17), 1);
    chk("ovf_drop", 32'(drop), 1);
`ifdef REPLAY_BUF_STATS_EN
    chk("ovf_drop_cnt", 32'(drop_cnt), 2);
`endif
    cyc(1, 0, '0, 1);
    chk("ovf_s0", 32'(out_data), 1);
    cyc(0, 1, 8'h7E, 1);
    chk("ovf_s1", 32'(out_data), 2);
    cyc(0, 1, 8'h7F, 1);
    chk("ovf_s2", 32'(out_data), 3);
    cyc(1, 0, '0, 1);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_ch",   32'(out_ch),  0);
    chk("ovr_slot", 32'(out_slot), 0);
    chk("ovr_data", 32'(out_data), 32'hE);
    drain("ovr_end", 20);

    // Asynchronous reset mid-replay.
    cyc(1, 0, '0, 1);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);
    #2 grst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data",  32'(out_data),  0);
    chk("arst_ch",    32'(out_ch),    0);
    chk("arst_slot",  32'(out_slot),  0);
    chk("arst_last",  32'(out_last),  0);
    chk("arst_drop",  32'(drop),      0);
    chk("arst_ovr",   32'(overrun),   0);
    @(negedge clk);
    grst = 1'b0;
    cyc(1, 1, 8'h5A, 1);
    chk("arst_gs1", 32'(out_valid), 0);
    cyc(0, 0, '0, 1);
    chk("arst_gs1b", 32'(out_valid), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++)
      cyc(($urandom_range(0, 13) == 0), ($urandom_range(0, 2) != 0), 8'($urandom),
          ($urandom_range(0, 3) != 0));
    drain("rand_end", 40);

`ifdef REPLAY_BUF_STATS_EN
    chk("st_drop", 32'(drop_cnt),    32'(m_drop_n));
    chk("st_ovr",  32'(overrun_cnt), 32'(m_ovr_n));
    chk("st_win",  32'(win_cnt),     32'(m_win_n));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
